// File: rtl/key_debounce.sv
// Per-key pushbutton debouncer: 2-flop synchronizer, stable-count filter,
// registered press/release strobes and a clearable sticky press flag.

module key_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CW              = 19
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  input  logic clear,
  output logic level,
  output logic press,
  output logic rel,
  output logic sticky
);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic [CW-1:0] cnt;
  logic          differ, done, accept_press;

  assign differ       = (sync2 != level);
  assign done         = differ && (cnt == TERM);
  assign accept_press = done && !sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      level  <= 1'b1;
      cnt    <= '0;
      press  <= 1'b0;
      rel    <= 1'b0;
      sticky <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= accept_press;
      rel   <= done && sync2;
      // Any return to the accepted level restarts the stability window.
      if (!differ)   cnt <= '0;
      else if (done) begin
        cnt   <= '0;
        level <= sync2;
      end else       cnt <= cnt + CW'(1);
      // A press accepted on the same edge as a clear wins.
      if (accept_press) sticky <= 1'b1;
      else if (clear)   sticky <= 1'b0;
    end
  end
endmodule

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NUM_KEYS        = 4
) (
  input  logic                clk_clk,
  input  logic                reset_reset,
  input  logic [NUM_KEYS-1:0] key_n_raw,
  input  logic [NUM_KEYS-1:0] clear_i,
  output logic [NUM_KEYS-1:0] keys_export,
  output logic [NUM_KEYS-1:0] press_pulse,
  output logic [NUM_KEYS-1:0] release_pulse,
  output logic [NUM_KEYS-1:0] pressed_sticky
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_lane
    key_debounce_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CW             (CW)
    ) u_lane (
      .clk   (clk_clk),
      .rst   (reset_reset),
      .key_n (key_n_raw[k]),
      .clear (clear_i[k]),
      .level (keys_export[k]),
      .press (press_pulse[k]),
      .rel   (release_pulse[k]),
      .sticky(pressed_sticky[k])
    );
  end
endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed literal scenarios plus a random phase,
// all cycles compared against a sample-window reference model.

module tb_key_debounce;
  localparam int DB = 8;
  localparam int NK = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] raw, clr;
  logic [NK-1:0] keys, pp, rp, st;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  key_debounce #(.DEBOUNCE_CYCLES(DB), .NUM_KEYS(NK)) dut (
    .clk_clk       (clk),
    .reset_reset   (rst),
    .key_n_raw     (raw),
    .clear_i       (clr),
    .keys_export   (keys),
    .press_pulse   (pp),
    .release_pulse (rp),
    .pressed_sticky(st)
  );

  always #5 clk = ~clk;

  // Reference: a key flips once the last DB synchronized samples all
  // disagree with the accepted level.
  logic [NK-1:0] m_s1, m_s2, m_exp, m_press, m_rel, m_sticky;
  logic [NK-1:0] hist [DB];

  task automatic model_step();
    bit acc;
    if (rst) begin
      m_s1 = '1; m_s2 = '1; m_exp = '1;
      m_press = '0; m_rel = '0; m_sticky = '0;
      for (int j = 0; j < DB; j++) hist[j] = '1;
    end else begin
      for (int j = DB - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = m_s2;
      for (int i = 0; i < NK; i++) begin
        acc = 1'b1;
        for (int j = 0; j < DB; j++) if (hist[j][i] == m_exp[i]) acc = 1'b0;
        m_press[i] = acc && m_exp[i];
        m_rel[i]   = acc && !m_exp[i];
        if (m_press[i])  m_sticky[i] = 1'b1;
        else if (clr[i]) m_sticky[i] = 1'b0;
        if (acc) m_exp[i] = ~m_exp[i];
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if ({keys, pp, rp, st} !== {m_exp, m_press, m_rel, m_sticky}) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t got keys=%h press=%h rel=%h sticky=%h want keys=%h press=%h rel=%h sticky=%h",
                 $time, keys, pp, rp, st, m_exp, m_press, m_rel, m_sticky);
      end
    end
  end

  task automatic lit(input string name, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s t=%0t got {keys,press,rel,sticky}=%h want %h", name, $time, got, want);
    end
  endtask

  logic [3:0] ek, ep, er, es;

  initial begin
    rst = 1'b1; raw = '1; clr = '0;
    @(negedge clk); chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      lit("idle", {keys, pp, rp, st}, 16'hF000);
    end

    raw[0] = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      ek = (n >= 10) ? 4'hE : 4'hF;
      ep = (n == 10) ? 4'h1 : 4'h0;
      es = (n >= 10) ? 4'h1 : 4'h0;
      lit("k0_press", {keys, pp, rp, st}, {ek, ep, 4'h0, es});
    end

    clr = 4'h1;
    @(negedge clk);
    clr = '0;
    lit("k0_clear", {keys, pp, rp, st}, 16'hE000);

    raw[1] = 1'b0;
    repeat (5) @(negedge clk);
    raw[1] = 1'b1;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      lit("k1_bounce", {keys, pp, rp, st}, 16'hE000);
    end

    raw[1] = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      ek = (n >= 10) ? 4'hC : 4'hE;
      ep = (n == 10) ? 4'h2 : 4'h0;
      es = (n >= 10) ? 4'h2 : 4'h0;
      lit("k1_press", {keys, pp, rp, st}, {ek, ep, 4'h0, es});
    end

    raw[2] = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      ek = (n >= 10) ? 4'h8 : 4'hC;
      ep = (n == 10) ? 4'h4 : 4'h0;
      es = (n >= 10) ? 4'h6 : 4'h2;
      lit("k2_set_wins", {keys, pp, rp, st}, {ek, ep, 4'h0, es});
      if (n == 9)  clr = 4'h4;
      if (n == 10) clr = '0;
    end

    raw = '1;
    repeat (14) @(negedge clk);
    clr = '1;
    @(negedge clk);
    clr = '0;
    @(negedge clk);
    lit("all_released", {keys, pp, rp, st}, 16'hF000);

    for (int n = 1; n <= 36; n++) begin
      if (n == 1)  raw[2] = 1'b0;
      if (n == 4)  raw[3] = 1'b0;
      if (n == 20) raw[2] = 1'b1;
      if (n == 23) raw[3] = 1'b1;
      @(negedge clk);
      ep = ((n == 10) ? 4'h4 : 4'h0) | ((n == 13) ? 4'h8 : 4'h0);
      er = ((n == 29) ? 4'h4 : 4'h0) | ((n == 32) ? 4'h8 : 4'h0);
      lit("k23_pulses", {8'h00, pp, rp}, {8'h00, ep, er});
    end
    lit("k23_done", {keys, 12'h000}, {4'hF, 12'h000});

    raw[0] = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lit("rst_mid", {keys, pp, rp, st}, 16'hF000);
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      ek = (n >= 10) ? 4'hE : 4'hF;
      ep = (n == 10) ? 4'h1 : 4'h0;
      lit("rst_full_wait", {keys, pp, rp, 4'h0}, {ek, ep, 4'h0, 4'h0});
    end
    raw = '1;
    repeat (12) @(negedge clk);

    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NK; i++) begin
        if ($urandom_range(0, 99) < 4) raw[i] = ~raw[i];
        clr[i] = ($urandom_range(0, 99) < 5);
      end
      rst = ($urandom_range(0, 499) == 0);
      @(negedge clk);
    end
    rst = 1'b0; clr = '0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
